dcram_bist_ctl: RTL and testbench
=================================

// Module: dcram_bist_ctl
// PURPOSE
//  March C- BIST sequencer for the D-cache data RAM array. On request it takes
//  over the RAM address/data/write-enable inputs and runs a six-element march.
//  It compares each read against the expected background and reports a sticky
//  pass/fail flag (dcache_test_err_l) plus the first failing address.
//  Sits between the test-mode pins and the dcram array input muxes.
// PARAMETERS
//  AW  11  word address width; N = 2**AW 64-bit words (bist_addr = addr[dc_msb:2])
//  DW  64  RAM data width; fixed 64 in this design
// PORTS
//  clk               in   1   core clock, all state on rising edge
//  reset_l           in   1   asynchronous active-low reset
//  bist_mode         in   2   00 off; 01 solid (0/1) bkgnd; 10 checkerboard; 11 = 01
//  bist_reset        in   1   sync clear: forces IDLE, clears err, fail_addr, done
//  data_out          in   DW  RAM read data, valid 1 cycle after read address
//  bist_active       out  1   mux select: 1 = RAM driven by bist_* outputs
//  bist_addr         out  AW  RAM word address
//  bist_data_in      out  DW  RAM write data
//  bist_we           out  4   RAM lane write enables (all 4 asserted on writes)
//  bist_done         out  1   march finished; held until bist_reset/mode 00
//  dcache_test_err_l out  1   sticky, low = a compare mismatch has occurred
//  fail_addr         out  AW  address of the first mismatch
// BEHAVIOUR
//  Reset (reset_l=0): state IDLE; bist_active=0, bist_addr=0, bist_data_in=0,
//   bist_we=0, bist_done=0, dcache_test_err_l=1, fail_addr=0.
//  Backgrounds: B0 = all 0 (mode 01/11) or 64'h5555_5555_5555_5555 (mode 10);
//   B1 = ~B0.
//  March elements: M0 up(wB0); M1 up(rB0,wB1); M2 up(rB1,wB0);
//   M3 down(rB0,wB1); M4 down(rB1,wB0); M5 down(rB0).
//   "up" runs 0..N-1 and "down" runs N-1..0.
//  States: IDLE, WR, RD, FLUSH, DONE. A 3-bit elem counter selects the element.
//   A read-write element spends 1 RD cycle then 1 WR cycle at each address.
//   M0 uses 1 WR cycle per address; M5 uses 1 RD cycle per address.
//  IDLE -> WR(M0, addr 0) on the first cycle bist_mode!=00 while done=0.
//   bist_active asserts that same edge.
//  Element end (addr at its terminal value, last op) -> next element.
//   The address reloads to 0 for up elements and to N-1 for down elements.
//   There are no idle cycles between elements.
//  After the M5 read at addr 0 -> FLUSH (1 cycle, final compare) -> DONE.
//  DONE: bist_done=1, bist_active=0, bist_we=0; stays until bist_mode==00 or
//   bist_reset. It then returns to IDLE with done cleared; err is kept unless
//   bist_reset.
//  Total run length: 10N op cycles + 1 FLUSH cycle; bist_done rises on cycle 10N+2.
//  Compare pipeline: each RD cycle registers exp_data, cmp_vld and rd_addr.
//   The next cycle compares data_out against exp_data.
//   On a mismatch with err_l==1: err_l<=0 and fail_addr<=rd_addr.
//   Later mismatches do not update fail_addr.
//  Writes: bist_we=4'hf only in WR cycles, 0 otherwise.
//   bist_data_in holds the expected/written background in both RD and WR.
//  Abort: bist_mode->00 in any non-IDLE state -> IDLE next cycle.
//   bist_active, bist_we and cmp_vld drop that edge (the in-flight compare is
//   discarded). err/fail_addr are retained.
//  bist_reset has priority over bist_mode in the same cycle.
//  A bist_mode change between nonzero values mid-run is ignored.
//   The background is latched at start.
//  bist_addr arithmetic is AW-bit modular, but the counter never wraps within
//   an element; the terminal detect uses ==N-1 or ==0.
// TESTING
//  AW=4, ideal RAM model, mode 01 -> 161 op+flush cycles; bist_done high at
//   cycle 162; err_l stays 1.
//  Same, mode 10 -> RAM sees writes of 5555.. then AAAA..; pass. Check the
//   M3 address sequence is 15..0.
//  Inject a stuck-at-1 on bit 7 at addr 9 -> err_l falls 1 cycle after the
//   M1 read of addr 9; fail_addr=9.
//  Inject faults at addrs 3 and 12 -> fail_addr=3 (first only); err_l stays 0
//   through DONE.
//  Drop mode to 00 mid-M2 -> bist_active=0 and bist_we=0 next cycle; IDLE.
//   Re-raise mode -> a fresh run starts at M0 addr 0.
//  bist_reset in DONE with err_l=0 -> err_l=1, fail_addr=0, done=0.
//   reset_l pulse mid-run -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/dcram_bist_ctl.sv
// March C- BIST sequencer for the D-cache data RAM array.
// Takes over the RAM address/data/write-enable inputs, runs a six-element
// march with a solid or checkerboard background, compares every read and
// keeps a sticky error flag plus the address of the first failing read.
module dcram_bist_ctl #(
  parameter int AW = 11,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic [1:0]    bist_mode,
  input  logic          bist_reset,
  input  logic [DW-1:0] data_out,
  output logic          bist_active,
  output logic [AW-1:0] bist_addr,
  output logic [DW-1:0] bist_data_in,
  output logic [3:0]    bist_we,
  output logic          bist_done,
  output logic          dcache_test_err_l,
  output logic [AW-1:0] fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] ADDR_LAST = '1;
  localparam logic [DW-1:0] CHECKER   = {(DW/2){2'b01}};

  state_t        state;
  logic [2:0]    elem;       // march element M0..M5
  logic [DW-1:0] bg0;        // background B0 latched at start; B1 = ~bg0
  logic          cmp_vld;    // a read was issued last cycle
  logic [DW-1:0] exp_data;   // value that read must return
  logic [AW-1:0] rd_addr;    // address of that read

  // Next march operation as seen from the current RD/WR op
  state_t        step_state;
  logic [2:0]    step_elem;
  logic [AW-1:0] step_addr;
  logic [DW-1:0] step_bg;
  logic          addr_last;
  logic          bist_abort;

  // Elements M0..M2 walk upwards, M3..M5 walk downwards
  function automatic logic elem_up(input logic [2:0] e);
    return (e <= 3'd2);
  endfunction

  // Background read in each element: M2 and M4 read B1, the rest read B0
  function automatic logic [DW-1:0] rd_bg(input logic [2:0] e, input logic [DW-1:0] b0);
    return ((e == 3'd2) || (e == 3'd4)) ? ~b0 : b0;
  endfunction

  // Background written in each element: M1 and M3 write B1, the rest write B0
  function automatic logic [DW-1:0] wr_bg(input logic [2:0] e, input logic [DW-1:0] b0);
    return ((e == 3'd1) || (e == 3'd3)) ? ~b0 : b0;
  endfunction

  assign bist_abort = (state != S_IDLE) && (bist_mode == 2'b00);

  // March stepping: read->write within an address, then advance or change element
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    step_state = state;
    step_elem  = elem;
    step_addr  = bist_addr;
    step_bg    = bist_data_in;
    addr_last  = elem_up(elem) ? (bist_addr == ADDR_LAST) : (bist_addr == '0);

    if (state == S_RD && elem != 3'd5) begin
      // Read half of a read-write element: write the same address next
      step_state = S_WR;
    end else if (state == S_RD || state == S_WR) begin
      if (addr_last) begin
        if (elem == 3'd5) begin
          // Final M5 read at address 0: one cycle to drain its compare
          step_state = S_FLUSH;
        end else begin
          // M1..M5 all begin with a read at their start address
          step_elem  = elem + 3'd1;
          step_state = S_RD;
          step_addr  = elem_up(elem + 3'd1) ? '0 : ADDR_LAST;
        end
      end else begin
        step_state = (elem == 3'd0) ? S_WR : S_RD;
        step_addr  = elem_up(elem) ? (bist_addr + AW'(1)) : (bist_addr - AW'(1));
      end
    end

    if (step_state == S_WR) begin
      step_bg = wr_bg(step_elem, bg0);
    end else if (step_state == S_RD) begin
      step_bg = rd_bg(step_elem, bg0);
    end
  end

  // Sequencer, registered RAM controls and compare pipeline
  always_ff @(posedge clk or negedge reset_l) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_l) begin
      state             <= S_IDLE;
      elem              <= 3'd0;
      bg0               <= '0;
      cmp_vld           <= 1'b0;
      exp_data          <= '0;
      rd_addr           <= '0;
      bist_active       <= 1'b0;
      bist_addr         <= '0;
      bist_data_in      <= '0;
      bist_we           <= 4'h0;
      bist_done         <= 1'b0;
      dcache_test_err_l <= 1'b1;
      fail_addr         <= '0;
    end else if (bist_reset) begin
      state             <= S_IDLE;
      elem              <= 3'd0;
      cmp_vld           <= 1'b0;
      bist_active       <= 1'b0;
      bist_addr         <= '0;
      bist_data_in      <= '0;
      bist_we           <= 4'h0;
      bist_done         <= 1'b0;
      dcache_test_err_l <= 1'b1;
      fail_addr         <= '0;
    end else if (bist_abort) begin
      // Mode dropped: release the RAM, discard the in-flight compare, keep err
      state       <= S_IDLE;
      cmp_vld     <= 1'b0;
      bist_active <= 1'b0;
      bist_we     <= 4'h0;
      bist_done   <= 1'b0;
    end else begin
      // Compare the read issued last cycle; only the first failure is recorded
      if (cmp_vld && (data_out != exp_data) && dcache_test_err_l) begin
        dcache_test_err_l <= 1'b0;
        fail_addr         <= rd_addr;
      end

      cmp_vld  <= (state == S_RD);
      exp_data <= bist_data_in;
      rd_addr  <= bist_addr;

      case (state)
        S_IDLE: begin
          if (bist_mode != 2'b00 && !bist_done) begin
            state        <= S_WR;
            elem         <= 3'd0;
            bg0          <= (bist_mode == 2'b10) ? CHECKER : '0;
            bist_data_in <= (bist_mode == 2'b10) ? CHECKER : '0;
            bist_addr    <= '0;
            bist_we      <= 4'hf;
            bist_active  <= 1'b1;
          end
        end
        S_WR, S_RD: begin
          state        <= step_state;
          elem         <= step_elem;
          bist_addr    <= step_addr;
          bist_data_in <= step_bg;
          bist_we      <= (step_state == S_WR) ? 4'hf : 4'h0;
        end
        S_FLUSH: begin
          state       <= S_DONE;
          bist_done   <= 1'b1;
          bist_active <= 1'b0;
          bist_we     <= 4'h0;
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcram_bist_ctl.sv
// Directed bench for dcram_bist_ctl with AW=4 (16 words) and a behavioural
// synchronous RAM that can force bit 7 high on reads of selected addresses.
module tb_dcram_bist_ctl;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int N  = 16;
  localparam int MAX_CYC = 400;

  logic          clk;
  logic          reset_l;
  logic [1:0]    bist_mode;
  logic          bist_reset;
  logic [DW-1:0] data_out;
  logic          bist_active;
  logic [AW-1:0] bist_addr;
  logic [DW-1:0] bist_data_in;
  logic [3:0]    bist_we;
  logic          bist_done;
  logic          dcache_test_err_l;
  logic [AW-1:0] fail_addr;

  int n_checks = 0;
  int n_errs   = 0;

  // Per-cycle log of the run in progress, indexed by cycle number from start
  logic [AW-1:0] addr_log [MAX_CYC+1];
  logic [3:0]    we_log   [MAX_CYC+1];
  logic [DW-1:0] data_log [MAX_CYC+1];
  int            first_err_cyc;

  logic [DW-1:0] mem [N];
  logic [N-1:0]  stuck7;

  dcram_bist_ctl #(.AW(AW), .DW(DW)) dut (
    .clk               (clk),
    .reset_l           (reset_l),
    .bist_mode         (bist_mode),
    .bist_reset        (bist_reset),
    .data_out          (data_out),
    .bist_active       (bist_active),
    .bist_addr         (bist_addr),
    .bist_data_in      (bist_data_in),
    .bist_we           (bist_we),
    .bist_done         (bist_done),
    .dcache_test_err_l (dcache_test_err_l),
    .fail_addr         (fail_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write on all-lane enable, read data one cycle after address
  always @(posedge clk) begin
    if (bist_we == 4'hf) mem[bist_addr] <= bist_data_in;
    data_out <= mem[bist_addr] | (stuck7[bist_addr] ? 64'h80 : 64'h0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Raise the mode and log each cycle until bist_done or the cycle budget runs out
  task automatic run_to_done(input logic [1:0] mode, output int cyc);
    @(negedge clk);
    bist_mode = mode;
    cyc = 0;
    first_err_cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      addr_log[cyc] = bist_addr;
      we_log[cyc]   = bist_we;
      data_log[cyc] = bist_data_in;
      if (!dcache_test_err_l && first_err_cyc == 0) first_err_cyc = cyc;
    end while (!bist_done && cyc < MAX_CYC);
  endtask

  task automatic clear_bist();
    @(negedge clk);
    bist_mode  = 2'b00;
    bist_reset = 1'b1;
    @(negedge clk);
    bist_reset = 1'b0;
  endtask

  initial begin
    int cyc;
    int n_wr;
    int bad;
    logic [DW-1:0] wr_data [80];

    reset_l    = 1'b0;
    bist_mode  = 2'b00;
    bist_reset = 1'b0;
    stuck7     = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;

    // Reset values
    #12;
    check("rst_active", bist_active, 0);
    check("rst_addr", bist_addr, 0);
    check("rst_data", bist_data_in, 0);
    check("rst_we", bist_we, 0);
    check("rst_done", bist_done, 0);
    check("rst_err_l", dcache_test_err_l, 1);
    check("rst_fail_addr", fail_addr, 0);
    @(negedge clk);
    reset_l = 1'b1;

    // Solid background, ideal RAM
    run_to_done(2'b01, cyc);
    check("m01_len", cyc, 162);
    check("m01_first_active", addr_log[1], 0);
    check("m01_first_we", we_log[1], 4'hf);
    n_wr = 0;
    for (int i = 1; i <= 160; i++) if (we_log[i] == 4'hf) n_wr++;
    check("m01_writes", n_wr, 80);
    check("m01_err_l", dcache_test_err_l, 1);
    check("m01_done_active", bist_active, 0);
    check("m01_done_we", bist_we, 0);
    @(negedge clk);
    check("m01_done_hold", bist_done, 1);
    clear_bist();
    check("clr_done", bist_done, 0);

    // Checkerboard background, ideal RAM
    run_to_done(2'b10, cyc);
    check("m10_len", cyc, 162);
    n_wr = 0;
    for (int i = 1; i <= 160; i++) begin
      if (we_log[i] == 4'hf && n_wr < 80) begin
        wr_data[n_wr] = data_log[i];
        n_wr++;
      end
    end
    check("m10_writes", n_wr, 80);
    check("m10_wr_m0", wr_data[0], 64'h5555_5555_5555_5555);
    check("m10_wr_m1", wr_data[16], 64'haaaa_aaaa_aaaa_aaaa);
    check("m10_wr_m2", wr_data[32], 64'h5555_5555_5555_5555);
    check("m10_rd_m2", data_log[49], 64'haaaa_aaaa_aaaa_aaaa);
    // M3 occupies op cycles 81..112: a read and a write at each of 15..0
    check("m10_m3_start", addr_log[81], 15);
    check("m10_m3_end", addr_log[112], 0);
    bad = 0;
    for (int k = 0; k < 32; k++) if (addr_log[81+k] != AW'(15 - k/2)) bad++;
    check("m10_m3_seq", bad, 0);
    check("m10_err_l", dcache_test_err_l, 1);
    clear_bist();

    // Stuck-at-1 on bit 7 at address 9: M1 reads addr 9 in cycle 35
    stuck7 = 16'h0200;
    run_to_done(2'b01, cyc);
    check("sa9_len", cyc, 162);
    check("sa9_err_cyc", first_err_cyc, 37);
    check("sa9_fail_addr", fail_addr, 9);
    check("sa9_err_l", dcache_test_err_l, 0);
    clear_bist();
    check("clr_err_l", dcache_test_err_l, 1);
    check("clr_fail_addr", fail_addr, 0);

    // Faults at 3 and 12: only the first is recorded, bist_reset in DONE clears
    stuck7 = 16'h1008;
    run_to_done(2'b01, cyc);
    check("sa2_fail_addr", fail_addr, 3);
    check("sa2_err_l", dcache_test_err_l, 0);
    check("sa2_done", bist_done, 1);
    @(negedge clk);
    bist_reset = 1'b1;
    @(negedge clk);
    bist_reset = 1'b0;
    check("brst_err_l", dcache_test_err_l, 1);
    check("brst_fail_addr", fail_addr, 0);
    check("brst_done", bist_done, 0);
    stuck7 = '0;

    // Abort mid-M2 then restart
    @(negedge clk);
    bist_mode = 2'b01;
    for (int i = 0; i < 60; i++) @(negedge clk);
    check("abt_active_before", bist_active, 1);
    bist_mode = 2'b00;
    @(negedge clk);
    check("abt_active", bist_active, 0);
    check("abt_we", bist_we, 0);
    @(negedge clk);
    check("abt_idle", bist_active, 0);
    run_to_done(2'b01, cyc);
    check("abt_restart_addr", addr_log[1], 0);
    check("abt_restart_we", we_log[1], 4'hf);
    check("abt_restart_len", cyc, 162);
    check("abt_err_l", dcache_test_err_l, 1);
    clear_bist();

    // Asynchronous reset mid-run with err already set
    stuck7 = 16'h0200;
    @(negedge clk);
    bist_mode = 2'b01;
    for (int i = 0; i < 40; i++) @(negedge clk);
    check("ar_pre_err_l", dcache_test_err_l, 0);
    check("ar_pre_addr", bist_addr, 11);
    #2;
    reset_l = 1'b0;
    #1;
    check("ar_active", bist_active, 0);
    check("ar_addr", bist_addr, 0);
    check("ar_data", bist_data_in, 0);
    check("ar_we", bist_we, 0);
    check("ar_err_l", dcache_test_err_l, 1);
    check("ar_fail_addr", fail_addr, 0);
    bist_mode = 2'b00;
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    check("ar_idle", bist_active, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
